sha3_pad_absorb: RTL and testbench

- Hardware SHA-3/SHAKE message front-end for the `keccak` core.
- Accepts a byte stream as W-bit words over a valid/ready handshake and packs it into R-bit rate blocks, R = 1600 − 2·D.
- Applies FIPS-202 multi-rate padding with a domain-separation suffix, and marks the first and last block of each message.
- Replaces the padding and packing currently done by software in benches, so the core can be fed directly from a stream source.

---
 rtl/sha3_pad_absorb.sv | 153 +++++++++++++++
 tb/tb_sha3_pad_absorb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_pad_absorb.sv
// SHA-3/SHAKE front-end: packs W-bit message words into R-bit rate blocks and applies pad10*1 with a domain suffix.
// Latency: a block is valid the cycle after the word completing it is accepted; an extra pad-only block follows when the message fills the block exactly.
// Backpressure: in_ready is high only while filling; blk_valid holds with stable outputs until blk_ready.
// Optional feature macro SHA3_PAD_SHAKE_EN: when defined, mode selects the SHAKE suffix 0x1F; otherwise the suffix is always 0x06.
module sha3_pad_absorb #(
    parameter int D = 512,
    parameter int W = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [$clog2(W/8):0]   in_bytes,
    input  logic                   mode,
    output logic [1600-2*D-1:0]    blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   blk_first,
    output logic                   blk_last
);
    localparam int R  = 1600 - 2 * D;
    localparam int NB = R / 8;
    localparam int WB = W / 8;
    localparam int NW = R / W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int BW = $clog2(W / 8) + 1;

    if (!(D == 224 || D == 256 || D == 384 || D == 512) || (W % 8) != 0 || W == 0 || (R % W) != 0) begin : g_param_chk
        $error("sha3_pad_absorb: illegal D/W combination");
    end

    typedef enum logic {FILL, EMIT} state_t;

    state_t          state;
    logic [CW-1:0]   wc;
    logic            first_pend;
    logic            pad_pend;
    logic            mode_q;
    logic [7:0]      word_sfx;
    logic [7:0]      pad_sfx;
    logic [BW-1:0]   inb_c;
    logic [R-1:0]    nxt_blk;
    logic [R-1:0]    pad_blk;
    logic            p_short;
    int              wc_i;
    int              p_i;

`ifdef SHA3_PAD_SHAKE_EN
    logic word_mode;
    // A message's first word supplies the mode directly; later words use the latched copy.
    assign word_mode = (wc == '0 && first_pend) ? mode : mode_q;
    assign word_sfx  = word_mode ? 8'h1F : 8'h06;
    assign pad_sfx   = mode_q ? 8'h1F : 8'h06;
`else
    logic unused_mode_q;
    assign unused_mode_q = mode_q;
    assign word_sfx      = 8'h06;
    assign pad_sfx       = 8'h06;
`endif

    assign inb_c   = (in_bytes > BW'(WB)) ? BW'(WB) : in_bytes;
    assign wc_i    = 32'(wc);
    assign p_i     = wc_i * WB + 32'(inb_c);
    assign p_short = (p_i < NB);

    // Merge the incoming word into its slot; on the last word also zero the tail and apply padding.
    always_comb begin
        nxt_blk = blk_data;
        for (int i = 0; i < NB; i++) begin
            if (i / WB == wc_i) begin
                if (!in_last || i < p_i)
                    nxt_blk[R-1-8*i -: 8] = in_data[W-1-8*(i%WB) -: 8];
                else if (i == p_i)
                    nxt_blk[R-1-8*i -: 8] = word_sfx;
                else
                    nxt_blk[R-1-8*i -: 8] = 8'h00;
            end else if (in_last && i / WB > wc_i) begin
                nxt_blk[R-1-8*i -: 8] = (i == p_i) ? word_sfx : 8'h00;
            end
        end
        if (in_last && p_short)
            nxt_blk[7:0] = nxt_blk[7:0] | 8'h80;
    end

    // Pad-only block used when the message ended exactly on a block boundary.
    always_comb begin
        pad_blk         = '0;
        pad_blk[R-1 -: 8] = pad_sfx;
        pad_blk[7:0]    = pad_blk[7:0] | 8'h80;
    end

    // Fill/emit controller; the block register doubles as the packing buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            in_ready   <= 1'b1;
            blk_valid  <= 1'b0;
            blk_data   <= '0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            wc         <= '0;
            first_pend <= 1'b1;
            pad_pend   <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        blk_data <= nxt_blk;
                        if (wc == '0 && first_pend)
                            mode_q <= mode;
                        if (in_last) begin
                            wc        <= '0;
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_first <= first_pend;
                            blk_last  <= p_short;
                            pad_pend  <= !p_short;
                        end else if (wc == CW'(NW - 1)) begin
                            wc        <= '0;
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_first <= first_pend;
                            blk_last  <= 1'b0;
                        end else begin
                            wc <= wc + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (blk_valid && blk_ready) begin
                        first_pend <= blk_last;
                        if (pad_pend) begin
                            blk_data  <= pad_blk;
                            blk_first <= blk_last;
                            blk_last  <= 1'b1;
                            pad_pend  <= 1'b0;
                        end else begin
                            state     <= FILL;
                            blk_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sha3_pad_absorb.sv
// Randomized bench for sha3_pad_absorb: byte-level FIPS-202 padding model, block scoreboard,
// stall stability checks and a mid-message reset.
module tb_sha3_pad_absorb;
    localparam int D  = 512;
    localparam int W  = 64;
    localparam int R  = 1600 - 2 * D;
    localparam int NB = R / 8;
    localparam int WB = W / 8;
    localparam int BW = $clog2(WB) + 1;

    typedef logic [7:0] u8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [BW-1:0] in_bytes = '0;
    logic          mode = 1'b0;
    logic [R-1:0]  blk_data;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic          blk_first;
    logic          blk_last;

    int n_cmp = 0;
    int n_bad = 0;
    bit hold_low = 1'b0;

    logic [R-1:0] exp_blk[$];
    bit           exp_first[$];
    bit           exp_last[$];

    sha3_pad_absorb #(.D(D), .W(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_bytes(in_bytes), .mode(mode), .blk_data(blk_data),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_first(blk_first), .blk_last(blk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [R-1:0] got, input logic [R-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: message || suffix || zeros, last byte |= 0x80, cut into NB-byte blocks.
    task automatic model(input u8 msg[$], input bit m);
        int len;
        int total;
        u8  pb[$];
        u8  sfx;
        logic [R-1:0] blk;
        len   = msg.size();
        total = (len / NB + 1) * NB;
`ifdef SHA3_PAD_SHAKE_EN
        sfx = m ? 8'h1F : 8'h06;
`else
        sfx = (m && 1'b0) ? 8'h1F : 8'h06;
`endif
        pb = msg;
        pb.push_back(sfx);
        while (pb.size() < total) pb.push_back(8'h00);
        pb[total-1] = pb[total-1] | 8'h80;
        for (int b = 0; b < total / NB; b++) begin
            blk = '0;
            for (int i = 0; i < NB; i++) blk[R-1-8*i -: 8] = pb[b*NB+i];
            exp_blk.push_back(blk);
            exp_first.push_back(b == 0);
            exp_last.push_back(b == total / NB - 1);
        end
    endtask

    task automatic wait_accept();
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", R'(0), R'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input u8 msg[$], input bit m, input bit extra_empty);
        int len;
        int nw;
        len = msg.size();
        nw  = (len == 0) ? 1 : (len + WB - 1) / WB;
        if (extra_empty && len > 0 && len % WB == 0) nw++;
        model(msg, m);
        for (int w = 0; w < nw; w++) begin
            logic [W-1:0] d;
            int cnt;
            int ib;
            d   = {$urandom, $urandom};
            cnt = len - w * WB;
            if (cnt > WB) cnt = WB;
            if (cnt < 0) cnt = 0;
            for (int j = 0; j < cnt; j++) d[W-1-8*j -: 8] = msg[w*WB+j];
            ib = cnt;
            if (w == nw - 1 && cnt == WB && $urandom_range(0, 1) == 1) ib = $urandom_range(15, WB);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = d;
            in_last  = (w == nw - 1);
            in_bytes = BW'(ib);
            mode     = (w == 0) ? m : 1'($urandom);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rand_msg(input int len, output u8 msg[$]);
        msg = {};
        for (int i = 0; i < len; i++) msg.push_back(u8'($urandom));
    endtask

    // Sink ready: random, or forced low during the stall test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            blk_ready = hold_low ? 1'b0 : (($urandom % 4) != 0);
        end
    end

    // Scoreboard plus hold-stable checking of stalled blocks.
    initial begin
        logic [R-1:0] prev_data;
        bit prev_first, prev_last, have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !blk_valid) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    check("hold_data", blk_data, prev_data);
                    check("hold_first", R'(blk_first), R'(prev_first));
                    check("hold_last", R'(blk_last), R'(prev_last));
                end
                check("in_ready_emit", R'(in_ready), R'(0));
                if (blk_ready) begin
                    if (exp_blk.size() == 0) begin
                        check("unexpected_blk", R'(1), R'(0));
                    end else begin
                        check("blk_data", blk_data, exp_blk.pop_front());
                        check("blk_first", R'(blk_first), R'(exp_first.pop_front()));
                        check("blk_last", R'(blk_last), R'(exp_last.pop_front()));
                    end
                    have_prev = 1'b0;
                end else begin
                    have_prev  = 1'b1;
                    prev_data  = blk_data;
                    prev_first = blk_first;
                    prev_last  = blk_last;
                end
            end
        end
    end

    initial begin
        u8 msg[$];
        int lens[16] = '{0, 3, 71, 72, 1, 7, 8, 9, 70, 73, 143, 144, 145, 200, 287, 288};
        int guard;
        logic [R-1:0] snap;

        #1 reset = 1'b1;
        #4;
        check("rst_in_ready", R'(in_ready), R'(1));
        check("rst_blk_valid", R'(blk_valid), R'(0));
        check("rst_blk_data", blk_data, R'(0));
        check("rst_blk_first", R'(blk_first), R'(0));
        check("rst_blk_last", R'(blk_last), R'(0));
        @(posedge clk); #1 reset = 1'b0;

        msg = {8'h61, 8'h62, 8'h63};
        send(msg, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            rand_msg(lens[k], msg);
            send(msg, 1'($urandom), 1'($urandom));
        end
        for (int k = 0; k < 20; k++) begin
            rand_msg($urandom_range(0, 300), msg);
            send(msg, 1'($urandom), 1'($urandom));
        end

        // Sink stalled for five cycles while a block is pending.
        hold_low = 1'b1;
        rand_msg(5, msg);
        send(msg, 1'b0, 1'b0);
        guard = 0;
        while (!blk_valid && guard < 50) begin @(negedge clk); guard++; end
        check("stall_blk_valid_seen", R'(blk_valid), R'(1));
        snap = blk_data;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", R'(blk_valid), R'(1));
            check("stall_data", blk_data, snap);
            check("stall_in_ready", R'(in_ready), R'(0));
        end
        hold_low = 1'b0;
        rand_msg(10, msg);
        send(msg, 1'b0, 1'b0);

        // Drain, then reset partway through a message.
        guard = 0;
        while (exp_blk.size() != 0 && guard < 2000) begin @(posedge clk); guard++; end
        check("drain1", R'(exp_blk.size()), R'(0));
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 4; w++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_last  = 1'b0;
            in_bytes = BW'(WB);
            wait_accept();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_in_ready", R'(in_ready), R'(1));
        check("mid_rst_blk_valid", R'(blk_valid), R'(0));
        check("mid_rst_blk_data", blk_data, R'(0));
        check("mid_rst_blk_first", R'(blk_first), R'(0));
        check("mid_rst_blk_last", R'(blk_last), R'(0));
        @(posedge clk); #1 reset = 1'b0;
        rand_msg(3, msg);
        send(msg, 1'b0, 1'b0);

        guard = 0;
        while (exp_blk.size() != 0 && guard < 2000) begin @(posedge clk); guard++; end
        check("drain2", R'(exp_blk.size()), R'(0));
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
